nway_mux_arbiter: RTL and testbench
===================================

Name: nway_mux_arbiter

Overview:
Parametrised successor to the gate-level 4:1 mux: N channels, W bits each, with a registered output stage.
Each input and the output use a valid/ready handshake.
Two selection modes:
- Fixed: channel chosen by the `sel` port.
- Round-robin: fair arbitration among channels that are valid.

It sits between multiple producers (e.g. writeback sources, operand buses) and a single consumer in the datapath.

Parameters:
WIDTH, 32, data width per channel in bits
NUM_CH, 4, number of input channels (2..16)
SEL_W, 2, select/index width; must equal max(1, clog2(NUM_CH))

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_data  input  NUM_CH*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH]
in_valid  input  NUM_CH  per-channel valid
in_ready  output  NUM_CH  per-channel ready (combinational)
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
out_data  output  WIDTH  registered selected data
out_ch  output  SEL_W  index of the channel that supplied out_data
out_valid  output  1  output holds valid data
out_ready  input  1  consumer accepts data

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low; assertion takes effect immediately regardless of clk.
- Reset values: out_valid=0, out_data=0, out_ch=0, round-robin pointer rr_ptr=0.
- Load enable: load_en = !out_valid || out_ready. The output register accepts a new word only when load_en=1.
- Grant (combinational, at most one-hot):
  - Fixed mode: grant channel `sel`, only if sel < NUM_CH and in_valid[sel]=1.
  - Round-robin mode: grant the first channel with in_valid=1, searching rr_ptr, rr_ptr+1, … modulo NUM_CH.
- Ready: in_ready[k] = load_en && (k is the granted channel, or, in fixed mode, k == sel). All other in_ready bits are 0.
  - A fixed-mode producer on `sel` sees ready even while its valid is low.
- Transfer: a transfer on channel k occurs when in_valid[k] && in_ready[k]. On that clk edge:
  - out_data <= channel k data
  - out_ch <= k
  - out_valid <= 1
- Drain: if load_en=1 and no transfer occurs, out_valid <= 0 at the clk edge. out_data and out_ch hold their last values.
- Stall: while out_valid=1 and out_ready=0, out_data, out_ch and out_valid hold stable, and all in_ready bits are 0.
- Latency and throughput: 1 cycle from input transfer to out_valid. Throughput is one word per cycle when out_ready is held at 1.
- Round-robin pointer:
  - Updates only on a round-robin-mode transfer: rr_ptr <= (k+1) mod NUM_CH, with wrap handled for non-power-of-2 NUM_CH.
  - Fixed-mode transfers leave rr_ptr unchanged.
- Mode or sel change: takes effect on the next grant evaluation. A word already held in the output register is unaffected.
- Out-of-range sel: in fixed mode with sel >= NUM_CH there is no grant, all in_ready bits are 0, and no transfer occurs.
- No valid inputs: no grant. The output drains per the drain rule.
- Reset during a pending stall: the held word is discarded and out_valid drops to 0 immediately.
- Behaviour is undefined only for NUM_CH < 2. Elaboration must fail if SEL_W < clog2(NUM_CH).

Test Plan:
- Reset: assert reset_n=0 mid-stream with out_valid=1 → out_valid, out_data and out_ch go to 0 asynchronously. After release, the first round-robin grant starts at channel 0.
- Fixed mode: mode=0, sel=2, in_data ch2=32'hA5A5_0002, all four channels valid, out_ready=1 → next cycle out_data=32'hA5A5_0002, out_ch=2. in_ready=4'b0100 every cycle.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles → out_ch sequence is 0,1,2,3,0,1,2,3, one word per cycle.
- Round-robin skip: mode=1, in_valid=4'b1010, rr_ptr=0 → grants ch1 then ch3 then ch1. rr_ptr becomes 2, 0, 2.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with inputs valid → out_data stable and in_ready=0. When out_ready rises, the stored word and a new word transfer on the same edge (no bubble).
- Boundary: NUM_CH=3, SEL_W=2, mode=0, sel=3 → in_ready=3'b000 and out_valid stays 0. In mode=1 with ch2 granted, rr_ptr wraps from 2 to 0.

Source files
------------

// File: rtl/nway_mux_arbiter.sv
// N-channel valid/ready multiplexer with a registered output stage.
// Selects by fixed index (sel) or by round-robin arbitration among valid channels.
module nway_mux_arbiter #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH*WIDTH-1:0]  in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    // Handshake: a word moves on any edge where valid && ready are both high;
    // in_ready never depends on in_valid of the same channel in fixed mode.

    generate
        if (SEL_W < $clog2(NUM_CH)) begin : g_bad_sel_w
            $error("nway_mux_arbiter: SEL_W too narrow for NUM_CH");
        end
    endgenerate

    localparam int              PAD_CH   = 2 ** SEL_W;
    localparam logic [SEL_W:0]  NUM_CH_X = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    logic [PAD_CH-1:0] valid_pad;
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  rr_idx;
    logic [SEL_W-1:0]  rr_next;
    logic [SEL_W:0]    rr_sum;
    logic              rr_found;
    logic              sel_ok;
    logic              fixed_hit;
    logic              grant_any;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  grant_data;
    logic              load_en;
    logic              xfer;

    // Padding lets an out-of-range index read a harmless zero instead of overflowing.
    assign valid_pad = PAD_CH'(in_valid);
    assign sel_ok    = ({1'b0, sel} < NUM_CH_X);
    assign fixed_hit = sel_ok && valid_pad[sel];

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_sum = {1'b0, rr_ptr} + (SEL_W + 1)'(i);
            if (rr_sum >= NUM_CH_X) begin
                rr_sum = rr_sum - NUM_CH_X;
            end
            if (!rr_found && valid_pad[rr_sum[SEL_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_sum[SEL_W-1:0];
            end
        end
    end

    assign grant_any = mode ? rr_found : fixed_hit;
    assign grant_idx = mode ? rr_idx : sel;
    assign load_en   = !out_valid || out_ready;
    assign xfer      = load_en && grant_any;
    assign rr_next   = (grant_idx == LAST_CH) ? '0 : grant_idx + SEL_W'(1);

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // In fixed mode the selected producer sees ready even before it raises valid.
    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ready
            assign in_ready[k] = load_en &&
                ((grant_any && (grant_idx == SEL_W'(k))) ||
                 (!mode && (sel == SEL_W'(k))));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= grant_data;
                out_ch   <= grant_idx;
                if (mode) begin
                    rr_ptr <= rr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_nway_mux_arbiter.sv
// Directed bench for nway_mux_arbiter: a 4-channel instance checked through an
// expected-word scoreboard, plus a 3-channel instance for non-power-of-2 wrap.
module tb_nway_mux_arbiter;

    logic         clk;
    logic         reset_n;

    // 4-channel, 32-bit instance
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic         mode;
    logic [1:0]   sel;
    logic [31:0]  out_data;
    logic [1:0]   out_ch;
    logic         out_valid;
    logic         out_ready;

    // 3-channel, 8-bit instance
    logic [23:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic         mode3;
    logic [1:0]   sel3;
    logic [7:0]   out_data3;
    logic [1:0]   out_ch3;
    logic         out_valid3;
    logic         out_ready3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] exp_q[$];

    typedef struct {
        logic        m;
        logic [1:0]  s;
        logic [3:0]  v;
        logic        r;
        logic [31:0] base;
        logic [3:0]  rdy;
        logic        push;
        logic        hold;
        logic [31:0] d;
        logic [1:0]  c;
    } vec_t;

    vec_t vecs[$];

    nway_mux_arbiter #(.WIDTH(32), .NUM_CH(4), .SEL_W(2)) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    nway_mux_arbiter #(.WIDTH(8), .NUM_CH(3), .SEL_W(2)) dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r,
                           input logic [31:0] base, input logic [3:0] rdy, input logic push,
                           input logic hold, input logic [31:0] d, input logic [1:0] c);
        vec_t t;
        t.m = m; t.s = s; t.v = v; t.r = r; t.base = base;
        t.rdy = rdy; t.push = push; t.hold = hold; t.d = d; t.c = c;
        vecs.push_back(t);
    endtask

    // Drive one vector after the active edge, check ready mid-cycle, log expected word.
    task automatic run_vec(input int idx);
        vec_t t;
        t = vecs[idx];
        @(posedge clk); #1;
        mode      = t.m;
        sel       = t.s;
        in_valid  = t.v;
        out_ready = t.r;
        for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = t.base | 32'(k);
        @(negedge clk);
        check($sformatf("in_ready v%0d", idx), 64'(in_ready), 64'(t.rdy));
        if (t.hold) begin
            check($sformatf("stall_valid v%0d", idx), 64'(out_valid), 64'(1));
            check($sformatf("stall_data v%0d", idx), 64'(out_data), 64'(t.d));
        end
        if (t.push) exp_q.push_back({t.d, t.c});
    endtask

    // Monitor: every accepted output word is popped and compared.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_word_unexpected", {30'd0, out_data, out_ch}, 64'h0);
                n_checks++;
                n_fail++;
                $display("FAIL out_word: got 0x%0h ch %0d, expected no word", out_data, out_ch);
            end else begin
                check("out_word", 64'({out_data, out_ch}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset_n    = 1'b1;
        in_data    = '0;
        in_valid   = '0;
        mode       = 1'b0;
        sel        = '0;
        out_ready  = 1'b0;
        in_data3   = {8'h32, 8'h31, 8'h30};
        in_valid3  = '0;
        mode3      = 1'b0;
        sel3       = '0;
        out_ready3 = 1'b1;

        // Fixed mode, sel=2, all valid
        for (int i = 0; i < 3; i++)
            add_vec(0, 2, 4'hF, 1, 32'hA5A5_0000, 4'b0100, 1, 0, 32'hA5A5_0002, 2);
        // Round-robin fairness: 0,1,2,3,0,1,2,3
        add_vec(1, 0, 4'hF, 1, 32'hC0DE_0000, 4'b0001, 1, 0, 32'hC0DE_0000, 0);
        add_vec(1, 0, 4'hF, 1, 32'hC0DE_0000, 4'b0010, 1, 0, 32'hC0DE_0001, 1);
        add_vec(1, 0, 4'hF, 1, 32'hC0DE_0000, 4'b0100, 1, 0, 32'hC0DE_0002, 2);
        add_vec(1, 0, 4'hF, 1, 32'hC0DE_0000, 4'b1000, 1, 0, 32'hC0DE_0003, 3);
        add_vec(1, 0, 4'hF, 1, 32'hC0DE_0000, 4'b0001, 1, 0, 32'hC0DE_0000, 0);
        add_vec(1, 0, 4'hF, 1, 32'hC0DE_0000, 4'b0010, 1, 0, 32'hC0DE_0001, 1);
        add_vec(1, 0, 4'hF, 1, 32'hC0DE_0000, 4'b0100, 1, 0, 32'hC0DE_0002, 2);
        add_vec(1, 0, 4'hF, 1, 32'hC0DE_0000, 4'b1000, 1, 0, 32'hC0DE_0003, 3);
        // Round-robin skip with valid=1010: ch1, ch3, ch1
        add_vec(1, 0, 4'b1010, 1, 32'h5EED_0000, 4'b0010, 1, 0, 32'h5EED_0001, 1);
        add_vec(1, 0, 4'b1010, 1, 32'h5EED_0000, 4'b1000, 1, 0, 32'h5EED_0003, 3);
        add_vec(1, 0, 4'b1010, 1, 32'h5EED_0000, 4'b0010, 1, 0, 32'h5EED_0001, 1);
        // Backpressure: 3 stalled cycles, then no-bubble resume from rr_ptr=2
        for (int i = 0; i < 3; i++)
            add_vec(1, 0, 4'hF, 0, 32'hBEEF_0000, 4'b0000, 0, 1, 32'h5EED_0001, 0);
        add_vec(1, 0, 4'hF, 1, 32'hBEEF_0000, 4'b0100, 1, 0, 32'hBEEF_0002, 2);
        add_vec(1, 0, 4'hF, 1, 32'hBEEF_0000, 4'b1000, 1, 0, 32'hBEEF_0003, 3);
        // Fixed mode, selected channel idle: ready shown, nothing moves
        add_vec(0, 1, 4'h0, 1, 32'h0, 4'b0010, 0, 0, 32'h0, 0);
        add_vec(0, 1, 4'h0, 1, 32'h0, 4'b0010, 0, 0, 32'h0, 0);
        // Load one word then stall it (discarded by reset below)
        add_vec(1, 0, 4'hF, 1, 32'h7777_0000, 4'b0001, 1, 0, 32'h7777_0000, 0);
        add_vec(1, 0, 4'hF, 0, 32'h7777_0000, 4'b0000, 0, 1, 32'h7777_0000, 0);
        // After reset the round-robin pointer starts at channel 0 again
        add_vec(1, 0, 4'hF, 1, 32'h9999_0000, 4'b0001, 1, 0, 32'h9999_0000, 0);
        add_vec(1, 0, 4'h0, 1, 32'h9999_0000, 4'b0000, 0, 0, 32'h0, 0);

        // Initial reset
        #1 reset_n = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_ch", 64'(out_ch), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i <= 22; i++) run_vec(i);

        // Asynchronous reset in the middle of a stall
        #2;
        in_valid = '0;
        reset_n  = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'(0));
        check("async_rst_out_data", 64'(out_data), 64'(0));
        check("async_rst_out_ch", 64'(out_ch), 64'(0));
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 23; i <= 24; i++) run_vec(i);

        repeat (3) @(negedge clk);
        check("drain_out_valid", 64'(out_valid), 64'(0));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        // 3-channel instance: out-of-range sel gives no ready and no transfer
        @(posedge clk); #1;
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        @(negedge clk);
        check("n3_oob_in_ready", 64'(in_ready3), 64'(0));
        check("n3_oob_out_valid", 64'(out_valid3), 64'(0));
        @(negedge clk);
        check("n3_oob_out_valid2", 64'(out_valid3), 64'(0));
        // Grant ch2, then pointer wraps to 0
        @(posedge clk); #1;
        mode3 = 1'b1; in_valid3 = 3'b100;
        @(negedge clk);
        check("n3_rr_in_ready_ch2", 64'(in_ready3), 64'(3'b100));
        @(posedge clk); #1;
        in_valid3 = 3'b111;
        @(negedge clk);
        check("n3_out_ch2", 64'(out_ch3), 64'(2));
        check("n3_out_data2", 64'(out_data3), 64'(8'h32));
        check("n3_wrap_in_ready", 64'(in_ready3), 64'(3'b001));
        @(posedge clk); #1;
        in_valid3 = 3'b000;
        @(negedge clk);
        check("n3_out_ch0", 64'(out_ch3), 64'(0));
        check("n3_out_data0", 64'(out_data3), 64'(8'h30));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
